// File: rtl/uart_pkg.sv
// Shared UART receive types: FSM states, error-flag bit positions and the FIFO entry layout.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_e;

  localparam int UartErrParity = 0;
  localparam int UartErrFrame  = 1;

  typedef struct packed {
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } uart_rx_entry_t;

  // Index of the final data bit for a data-bits-minus-5 setting.
  function automatic logic [2:0] last_data_idx(input logic [1:0] data_bits_m5);
    return {1'b0, data_bits_m5} + 3'd4;
  endfunction

endpackage

// File: rtl/fifo.sv
// Generic first-word-fall-through FIFO; head is visible while non-empty, and 0 when empty.
module fifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr,
  input  logic [Width-1:0] i_wdata,
  input  logic             i_rd,
  output logic [Width-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AddrBits = $clog2(Depth);

  logic [AddrBits:0] wr_ptr_q, wr_ptr_d;
  logic [AddrBits:0] rd_ptr_q, rd_ptr_d;
  logic [Width-1:0]  mem [Depth];
  logic              wr_en;
  logic              rd_en;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[AddrBits] != rd_ptr_q[AddrBits]) &&
                   (wr_ptr_q[AddrBits-1:0] == rd_ptr_q[AddrBits-1:0]);

  assign wr_en = i_wr && !o_full;
  assign rd_en = i_rd && !o_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + {{AddrBits{1'b0}}, 1'b1};
    if (rd_en) rd_ptr_d = rd_ptr_q + {{AddrBits{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AddrBits-1:0]] <= i_wdata;
  end

  assign o_rdata = o_empty ? '0 : mem[rd_ptr_q[AddrBits-1:0]];

endmodule

// File: rtl/uart_rx_frame.sv
// Run-time configurable UART receiver (5-8 data bits, optional parity, 1/2 stop bits) feeding a FIFO.
// Define UART_RX_SYNC_EN to pass i_rx through a 2-flop synchronizer (adds 2 cycles of latency).
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int FifoDepth   = 4,
  parameter int BaudCycBits = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [BaudCycBits-1:0] c_baud_cyc,
  input  logic [1:0]             c_data_bits,
  input  logic                   c_parity_en,
  input  logic                   c_parity_odd,
  input  logic                   c_stop2,
  input  logic                   i_rx,
  output logic                   o_busy,
  output logic                   o_fifo_empty,
  input  logic                   i_fifo_read,
  output logic [7:0]             o_fifo_rdata,
  output logic [1:0]             o_fifo_rerr,
  output logic                   o_overflow,
  input  logic                   i_ovf_clr
);

  localparam int CntW = BaudCycBits + 1;

  logic rx;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q, sync_d;

  assign sync_d = {sync_q[0], i_rx};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) sync_q <= 2'b11;
    else       sync_q <= sync_d;
  end

  assign rx = sync_q[1];
`else
  assign rx = i_rx;
`endif

  uart_rx_state_e         state_q, state_d;
  logic [BaudCycBits-1:0] cnt_q, cnt_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic                   stop_idx_q, stop_idx_d;
  logic [7:0]             data_q, data_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   push_q, push_d;
  uart_rx_entry_t         entry_q, entry_d;
  logic                   ovf_q, ovf_d;

  logic                   tick_baud;
  logic                   tick_sample;
  logic [CntW-1:0]        half_cyc;

  logic                   fifo_full;
  logic [$bits(uart_rx_entry_t)-1:0] fifo_rdata;
  uart_rx_entry_t         fifo_head;

  // Extra counter bit keeps (c_baud_cyc+1) from wrapping at the maximum period.
  assign half_cyc    = ({1'b0, c_baud_cyc} + CntW'(1)) >> 1;
  assign tick_baud   = (cnt_q == '0);
  assign tick_sample = ({1'b0, cnt_q} == half_cyc);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_idx_d = stop_idx_q;
    data_d     = data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    push_d     = 1'b0;
    entry_d    = entry_q;

    if (state_q != IDLE) begin
      cnt_d = tick_baud ? c_baud_cyc : cnt_q - BaudCycBits'(1);
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx) begin
          state_d = START;
          cnt_d   = c_baud_cyc;
          data_d  = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end

      START: begin
        if (tick_sample && rx) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (tick_baud) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end

      DATA: begin
        if (tick_sample) data_d[bit_cnt_q] = rx;
        if (tick_baud) begin
          if (bit_cnt_q == last_data_idx(c_data_bits)) begin
            state_d    = c_parity_en ? PARITY : STOP;
            stop_idx_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end

      PARITY: begin
        if (tick_sample) perr_d = rx ^ (^data_q) ^ c_parity_odd;
        if (tick_baud) begin
          state_d    = STOP;
          stop_idx_d = 1'b0;
        end
      end

      STOP: begin
        // Leave at mid-bit of the last stop bit so a back-to-back start bit is caught.
        if (tick_sample) begin
          ferr_d = ferr_q | ~rx;
          if (!c_stop2 || stop_idx_q) begin
            state_d      = IDLE;
            cnt_d        = '0;
            push_d       = 1'b1;
            entry_d.ferr = ferr_q | ~rx;
            entry_d.perr = perr_q;
            entry_d.data = data_q;
          end
        end else if (tick_baud) begin
          stop_idx_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Fullness is sampled before any same-cycle pop, so a push into a full FIFO always drops.
  always_comb begin
    ovf_d = ovf_q;
    if (i_ovf_clr)           ovf_d = 1'b0;
    if (push_q && fifo_full) ovf_d = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      stop_idx_q <= 1'b0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      push_q     <= 1'b0;
      entry_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_idx_q <= stop_idx_d;
      data_q     <= data_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      push_q     <= push_d;
      entry_q    <= entry_d;
      ovf_q      <= ovf_d;
    end
  end

  fifo #(
    .Width($bits(uart_rx_entry_t)),
    .Depth(FifoDepth)
  ) u_fifo (
    .clk    (i_clk),
    .rst_n  (~i_rst),
    .i_wr   (push_q),
    .i_wdata(entry_q),
    .i_rd   (i_fifo_read),
    .o_rdata(fifo_rdata),
    .o_full (fifo_full),
    .o_empty(o_fifo_empty)
  );

  assign fifo_head = uart_rx_entry_t'(fifo_rdata);

  assign o_busy                     = (state_q != IDLE);
  assign o_fifo_rdata               = fifo_head.data;
  assign o_fifo_rerr[UartErrParity] = fifo_head.perr;
  assign o_fifo_rerr[UartErrFrame]  = fifo_head.ferr;
  assign o_overflow                 = ovf_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: directed scenarios plus randomized frames vs. a frame-level model.
module tb_uart_rx_frame;

  localparam int DEPTH = 4;
`ifdef UART_RX_SYNC_EN
  localparam int SyncLat = 2;
`else
  localparam int SyncLat = 0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [15:0] c_baud_cyc = 16'd15;
  logic [1:0]  c_data_bits = 2'd3;
  logic        c_parity_en = 1'b0;
  logic        c_parity_odd = 1'b0;
  logic        c_stop2 = 1'b0;
  logic        i_rx = 1'b1;
  logic        o_busy;
  logic        o_fifo_empty;
  logic        i_fifo_read = 1'b0;
  logic [7:0]  o_fifo_rdata;
  logic [1:0]  o_fifo_rerr;
  logic        o_overflow;
  logic        i_ovf_clr = 1'b0;

  uart_rx_frame #(.FifoDepth(DEPTH), .BaudCycBits(16)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .c_baud_cyc  (c_baud_cyc),
    .c_data_bits (c_data_bits),
    .c_parity_en (c_parity_en),
    .c_parity_odd(c_parity_odd),
    .c_stop2     (c_stop2),
    .i_rx        (i_rx),
    .o_busy      (o_busy),
    .o_fifo_empty(o_fifo_empty),
    .i_fifo_read (i_fifo_read),
    .o_fifo_rdata(o_fifo_rdata),
    .o_fifo_rerr (o_fifo_rerr),
    .o_overflow  (o_overflow),
    .i_ovf_clr   (i_ovf_clr)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Monitors: cycle of the latest empty->non-empty change, and number of busy cycles seen.
  int fall_cyc = -1;
  int busy_cnt = 0;
  bit empty_prev = 1'b1;
  always @(negedge i_clk) begin
    if (empty_prev && !o_fifo_empty) fall_cyc = cyc;
    empty_prev = o_fifo_empty;
    if (o_busy) busy_cnt++;
  end

  int checks = 0;
  int failures = 0;

  logic [9:0] exp_q[$];
  bit         ovf_m = 1'b0;

  int cur_b = 16, cur_nb = 8, cur_ns = 1;
  bit cur_pen = 1'b0, cur_odd = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: the entry a frame should produce, from bit counts alone.
  function automatic logic [9:0] frame_entry(input logic [7:0] d, input bit pbit,
                                             input bit s0, input bit s1);
    int ones = 0;
    logic [7:0] m = '0;
    bit perr, ferr;
    for (int i = 0; i < cur_nb; i++) begin
      m[i] = d[i];
      ones += int'(d[i]);
    end
    perr = cur_pen ? (((ones + int'(pbit)) % 2) != int'(cur_odd)) : 1'b0;
    ferr = !s0 || (cur_ns == 2 && !s1);
    return {ferr, perr, m};
  endfunction

  function automatic int latency();
    return (1 + cur_nb + int'(cur_pen) + cur_ns - 1) * cur_b + (cur_b - cur_b / 2) + 1 + SyncLat;
  endfunction

  task automatic model_push(input logic [9:0] e);
    if (exp_q.size() >= DEPTH) ovf_m = 1'b1;
    else exp_q.push_back(e);
  endtask

  task automatic set_cfg(input int baud_cyc, input int nb, input bit pen, input bit odd, input bit s2);
    cur_b = baud_cyc + 1; cur_nb = nb; cur_pen = pen; cur_odd = odd; cur_ns = s2 ? 2 : 1;
    c_baud_cyc = 16'(baud_cyc); c_data_bits = 2'(nb - 5);
    c_parity_en = pen; c_parity_odd = odd; c_stop2 = s2;
  endtask

  task automatic drive_bit(input logic v);
    i_rx = v;
    repeat (cur_b) @(posedge i_clk);
    #1;
  endtask

  task automatic send_raw(input logic [7:0] d, input bit pbit, input bit s0, input bit s1);
    drive_bit(1'b0);
    for (int i = 0; i < cur_nb; i++) drive_bit(d[i]);
    if (cur_pen) drive_bit(pbit);
    drive_bit(s0);
    if (cur_ns == 2) drive_bit(s1);
    i_rx = 1'b1;
    repeat (2 * cur_b) @(posedge i_clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (o_busy && n < 2000) begin
      @(posedge i_clk); #1;
      n++;
    end
    check({tag, "_idle"}, 32'(o_busy), 32'd0);
  endtask

  task automatic frame(input string tag, input logic [7:0] d, input bit pbit, input bit s0, input bit s1);
    send_raw(d, pbit, s0, s1);
    model_push(frame_entry(d, pbit, s0, s1));
    wait_idle(tag);
    $display("frame %s data=0x%02h nb=%0d pen=%0d odd=%0d ns=%0d b=%0d", tag, d, cur_nb, cur_pen, cur_odd, cur_ns, cur_b);
  endtask

  task automatic read_expect(input string tag);
    logic [9:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_empty"}, 32'(o_fifo_empty), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_nonempty"}, 32'(o_fifo_empty), 32'd0);
      check({tag, "_data"}, 32'(o_fifo_rdata), 32'(e[7:0]));
      check({tag, "_rerr"}, 32'(o_fifo_rerr), 32'(e[9:8]));
      $display("read %s data=0x%02h rerr=%0b", tag, o_fifo_rdata, o_fifo_rerr);
      i_fifo_read = 1'b1;
      @(posedge i_clk); #1;
      i_fifo_read = 1'b0;
    end
  endtask

  task automatic clear_ovf();
    i_ovf_clr = 1'b1;
    @(posedge i_clk); #1;
    i_ovf_clr = 1'b0;
    ovf_m = 1'b0;
  endtask

  initial begin
    int start_cyc, lat, b0;
    logic [7:0] rd;

    repeat (3) @(posedge i_clk);
    #1;
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_empty", 32'(o_fifo_empty), 32'd1);
    check("rst_rdata", 32'(o_fifo_rdata), 32'd0);
    check("rst_rerr", 32'(o_fifo_rerr), 32'd0);
    check("rst_ovf", 32'(o_overflow), 32'd0);
    i_rst = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;

    // 8N1 at 16 cycles/bit: data and push latency.
    set_cfg(15, 8, 1'b0, 1'b0, 1'b0);
    start_cyc = cyc;
    lat = latency();
    frame("a5_8n1", 8'hA5, 1'b0, 1'b1, 1'b1);
    check("a5_latency", 32'(fall_cyc - start_cyc), 32'(lat + 1));
    read_expect("a5");
    read_expect("a5_after");

    // 5E2 with good then bad parity.
    set_cfg(9, 5, 1'b1, 1'b0, 1'b1);
    frame("13_5e2_p1", 8'h13, 1'b1, 1'b1, 1'b1);
    frame("13_5e2_p0", 8'h13, 1'b0, 1'b1, 1'b1);
    read_expect("13_p1");
    read_expect("13_p0");

    // 7O1 with framing error, then a clean frame.
    set_cfg(11, 7, 1'b1, 1'b1, 1'b0);
    frame("41_7o1_ferr", 8'h41, 1'b1, 1'b0, 1'b1);
    frame("7f_7o1", 8'h7F, 1'b0, 1'b1, 1'b1);
    read_expect("41");
    read_expect("7f");
    read_expect("7f_after");

    // Short low glitch on idle line.
    set_cfg(15, 8, 1'b0, 1'b0, 1'b0);
    b0 = busy_cnt;
    i_rx = 1'b0;
    repeat (4) @(posedge i_clk);
    #1;
    i_rx = 1'b1;
    repeat (40) @(posedge i_clk);
    #1;
    check("glitch_busy_seen", 32'(busy_cnt > b0), 32'd1);
    check("glitch_busy_end", 32'(o_busy), 32'd0);
    check("glitch_no_push", 32'(o_fifo_empty), 32'd1);
    $display("glitch busy_cycles=%0d", busy_cnt - b0);

    // Overflow: five frames into a 4-deep FIFO.
    set_cfg(7, 8, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      rd = 8'($urandom);
      frame("ovf_fill", rd, 1'b0, 1'b1, 1'b1);
    end
    check("ovf_set", 32'(o_overflow), 32'(ovf_m));
    clear_ovf();
    check("ovf_clr", 32'(o_overflow), 32'(ovf_m));
    for (int i = 0; i < DEPTH + 1; i++) read_expect("ovf_drain");

    // Pop in the same cycle as a push into a full FIFO: push still dropped.
    for (int i = 0; i < DEPTH; i++) begin
      rd = 8'($urandom);
      frame("full_fill", rd, 1'b0, 1'b1, 1'b1);
    end
    rd = 8'($urandom);
    lat = latency();
    fork
      send_raw(rd, 1'b0, 1'b1, 1'b1);
      begin
        repeat (lat) @(posedge i_clk);
        #1;
        i_fifo_read = 1'b1;
        @(posedge i_clk); #1;
        i_fifo_read = 1'b0;
      end
    join
    wait_idle("popfull");
    model_push(frame_entry(rd, 1'b0, 1'b1, 1'b1));
    void'(exp_q.pop_front());
    check("popfull_ovf", 32'(o_overflow), 32'(ovf_m));
    clear_ovf();
    for (int i = 0; i < DEPTH; i++) read_expect("popfull_drain");

    // Randomized configurations and frames, each read back immediately.
    for (int i = 0; i < 16; i++) begin
      set_cfg(int'($urandom_range(3, 12)), int'($urandom_range(5, 8)),
              1'($urandom), 1'($urandom), 1'($urandom));
      rd = 8'($urandom);
      frame("rand", rd, 1'($urandom), ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0));
      read_expect("rand");
      check("rand_ovf", 32'(o_overflow), 32'(ovf_m));
    end

    // Reset in the middle of the data bits.
    set_cfg(15, 8, 1'b0, 1'b0, 1'b0);
    frame("pre_rst", 8'h5A, 1'b0, 1'b1, 1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    check("mid_busy", 32'(o_busy), 32'd1);
    i_rst = 1'b1;
    #1;
    check("mrst_busy", 32'(o_busy), 32'd0);
    check("mrst_empty", 32'(o_fifo_empty), 32'd1);
    check("mrst_rdata", 32'(o_fifo_rdata), 32'd0);
    check("mrst_rerr", 32'(o_fifo_rerr), 32'd0);
    check("mrst_ovf", 32'(o_overflow), 32'd0);
    exp_q.delete();
    ovf_m = 1'b0;
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    i_rx = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    frame("post_rst", 8'hC3, 1'b0, 1'b1, 1'b1);
    read_expect("post_rst");
    read_expect("post_rst_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
